// File: rtl/dram_fifo_burst_sched.sv
// Ring-buffer burst scheduler for a DRAM-backed stream FIFO: one write or read burst outstanding, round-robin on ties.
// Command valid one cycle after a grant from IDLE; valid/addr/len held until ready; partial writes flush after an idle timeout.
module dram_fifo_burst_sched #(
    parameter int ADDR_WIDTH      = 30,
    parameter int FIFO_BASE       = 0,
    parameter int FIFO_SIZE_LOG2  = 24,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int BURST_LOG2      = 8,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int CNT_W          = FIFO_SIZE_LOG2 - BEAT_BYTES_LOG2 + 1
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [15:0]           in_occupied,
    input  logic [15:0]           out_space,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [7:0]            wr_cmd_len,
    input  logic                  wr_done,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]            rd_cmd_len,
    input  logic                  rd_beat,
    output logic [CNT_W-1:0]      occupied,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
);
    localparam int PTR_W = CNT_W - 1;
    localparam int LEN_W = BURST_LOG2 + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] RING_BEATS  = {1'b1, {PTR_W{1'b0}}};
    localparam logic [LEN_W-1:0] BURST_BEATS = {1'b1, {BURST_LOG2{1'b0}}};
    localparam logic [TMR_W-1:0] TIMEOUT     = TMR_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ISSUE = 3'd1;
    localparam logic [2:0] S_WR_RESP  = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_DATA  = 3'd4;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    logic [2:0]            state, state_nxt;
    logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]      occ_nxt, free_beats;
    logic [TMR_W-1:0]      timer, timer_nxt;
    logic [LEN_W-1:0]      rd_outst, rd_outst_nxt, len_q, len_nxt;
    logic [LEN_W-1:0]      wr_bnd, rd_bnd, wr_l, rd_l;
    logic                  last_grant, last_grant_nxt;
    logic                  wr_vld_nxt, rd_vld_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt, rd_addr_nxt;
    logic [7:0]            wr_len_nxt, rd_len_nxt;
    logic                  in_partial, wr_elig, rd_elig;

    // Bursts stop at the next burst-aligned boundary, so a ring wrap never splits one.
    assign wr_bnd     = BURST_BEATS - LEN_W'(wr_ptr[BURST_LOG2-1:0]);
    assign rd_bnd     = BURST_BEATS - LEN_W'(rd_ptr[BURST_LOG2-1:0]);
    assign free_beats = RING_BEATS - occupied;

    assign in_partial = (in_occupied != 16'd0) && (32'(in_occupied) < 32'(wr_bnd));
    assign wr_l       = in_partial ? LEN_W'(in_occupied) : wr_bnd;
    assign wr_elig    = (in_partial ? (timer == TIMEOUT) : (in_occupied != 16'd0))
                        && (32'(free_beats) >= 32'(wr_l));

    assign rd_l    = (32'(occupied) >= 32'(rd_bnd)) ? rd_bnd : LEN_W'(occupied);
    assign rd_elig = (occupied != '0) && (32'(out_space) >= 32'(rd_l));

    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        occ_nxt        = occupied;
        rd_outst_nxt   = rd_outst;
        len_nxt        = len_q;
        last_grant_nxt = last_grant;
        wr_vld_nxt     = wr_cmd_valid;
        rd_vld_nxt     = rd_cmd_valid;
        wr_addr_nxt    = wr_cmd_addr;
        rd_addr_nxt    = rd_cmd_addr;
        wr_len_nxt     = wr_cmd_len;
        rd_len_nxt     = rd_cmd_len;

        timer_nxt = timer;
        if (in_occupied == 16'd0) begin
            timer_nxt = '0;
        end else if (in_partial && (timer != TIMEOUT)) begin
            timer_nxt = timer + TMR_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (clear) begin
                    wr_ptr_nxt = '0;
                    rd_ptr_nxt = '0;
                    occ_nxt    = '0;
                    timer_nxt  = '0;
                end else if (enable && wr_elig && (!rd_elig || (last_grant == GRANT_RD))) begin
                    state_nxt      = S_WR_ISSUE;
                    len_nxt        = wr_l;
                    last_grant_nxt = GRANT_WR;
                    wr_vld_nxt     = 1'b1;
                    wr_addr_nxt    = ADDR_WIDTH'(FIFO_BASE) + (ADDR_WIDTH'(wr_ptr) << BEAT_BYTES_LOG2);
                    wr_len_nxt     = 8'(wr_l - LEN_W'(1));
                end else if (enable && rd_elig) begin
                    state_nxt      = S_RD_ISSUE;
                    len_nxt        = rd_l;
                    last_grant_nxt = GRANT_RD;
                    rd_vld_nxt     = 1'b1;
                    rd_addr_nxt    = ADDR_WIDTH'(FIFO_BASE) + (ADDR_WIDTH'(rd_ptr) << BEAT_BYTES_LOG2);
                    rd_len_nxt     = 8'(rd_l - LEN_W'(1));
                end
            end
            S_WR_ISSUE: begin
                if (wr_cmd_ready) begin
                    wr_vld_nxt = 1'b0;
                    wr_ptr_nxt = wr_ptr + PTR_W'(len_q);
                    timer_nxt  = '0;
                    state_nxt  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                // Data only counts as committed once the write response lands.
                if (wr_done) begin
                    occ_nxt   = occupied + CNT_W'(len_q);
                    state_nxt = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                if (rd_cmd_ready) begin
                    rd_vld_nxt   = 1'b0;
                    rd_ptr_nxt   = rd_ptr + PTR_W'(len_q);
                    occ_nxt      = occupied - CNT_W'(len_q);
                    rd_outst_nxt = len_q;
                    state_nxt    = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rd_beat && (rd_outst != '0)) begin
                    rd_outst_nxt = rd_outst - LEN_W'(1);
                    if (rd_outst == LEN_W'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupied     <= '0;
            timer        <= '0;
            rd_outst     <= '0;
            len_q        <= '0;
            last_grant   <= GRANT_RD;
            wr_cmd_valid <= 1'b0;
            rd_cmd_valid <= 1'b0;
            wr_cmd_addr  <= '0;
            rd_cmd_addr  <= '0;
            wr_cmd_len   <= '0;
            rd_cmd_len   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            occupied     <= occ_nxt;
            timer        <= timer_nxt;
            rd_outst     <= rd_outst_nxt;
            len_q        <= len_nxt;
            last_grant   <= last_grant_nxt;
            wr_cmd_valid <= wr_vld_nxt;
            rd_cmd_valid <= rd_vld_nxt;
            wr_cmd_addr  <= wr_addr_nxt;
            rd_cmd_addr  <= rd_addr_nxt;
            wr_cmd_len   <= wr_len_nxt;
            rd_cmd_len   <= rd_len_nxt;
            full         <= (occ_nxt == RING_BEATS);
            empty        <= (occ_nxt == '0);
            busy         <= (state_nxt != S_IDLE);
        end
    end
endmodule
